// File: rtl/display_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment table,
// blank pattern, decimal-point digit and digit count.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DP_DIGIT   = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment (gfedcba) decoder.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/pc_wb_display_scanner.sv
// Scans PC[15:0] (digits 7..4) and write-back data[15:0] (digits 3..0) onto an
// 8-digit common-anode display. Optional macro: LEADING_ZERO_BLANK_EN.
module pc_wb_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PC_pin_out,
  input  logic [31:0] write_data_pin,
  input  logic        Freeze,
  output logic [7:0]  An,
  output logic [7:0]  Seg,
  output logic        Frame_start
);

  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] digit_idx;
  logic [IDX_W-1:0] next_idx;
  logic [15:0]      pc_snap;
  logic [15:0]      wd_snap;
  logic [15:0]      pc_next;
  logic [15:0]      wd_next;
  logic             tick;
  logic             wrap;
  logic             latch;

  logic [1:0]       pos;
  logic [15:0]      group;
  logic [15:0]      upper;
  logic [3:0]       nibble;
  logic [6:0]       seg7;
  logic             dp;
  logic             blank;
  logic [7:0]       seg_next;
  logic             unused_hi;

  assign unused_hi = ^{PC_pin_out[31:16], write_data_pin[31:16]};

  assign tick     = (count == CNT_W'(REFRESH_DIV - 1));
  assign next_idx = digit_idx + 1'b1;
  assign wrap     = tick && (next_idx == '0);
  assign latch    = wrap && !Freeze;

  // Digit 0 of a new frame must show the values being latched this edge
  assign pc_next = latch ? PC_pin_out[15:0]     : pc_snap;
  assign wd_next = latch ? write_data_pin[15:0] : wd_snap;

  always_comb begin
    pos    = next_idx[1:0];
    group  = next_idx[2] ? pc_next : wd_next;
    upper  = group >> {pos, 2'b00};
    nibble = upper[3:0];
    dp     = (next_idx != IDX_W'(DP_DIGIT));
    blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // Lowest digit of each group always shows, so a zero value reads "0"
    blank  = (pos != 2'd0) && (upper == 16'h0000);
`endif
    seg_next = blank ? {dp, SEG_BLANK[6:0]} : {dp, seg7};
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (seg7)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count       <= '0;
      digit_idx   <= IDX_W'(NUM_DIGITS - 1);
      pc_snap     <= '0;
      wd_snap     <= '0;
      An          <= 8'hFF;
      Seg         <= SEG_BLANK;
      Frame_start <= 1'b0;
    end else begin
      count       <= tick ? '0 : count + 1'b1;
      Frame_start <= wrap;
      if (tick) begin
        digit_idx <= next_idx;
        pc_snap   <= pc_next;
        wd_snap   <= wd_next;
        An        <= ~(8'h01 << next_idx);
        Seg       <= seg_next;
      end
    end
  end

endmodule

// File: tb/tb_pc_wb_display_scanner.sv
// Randomized bench for pc_wb_display_scanner with REFRESH_DIV = 4; the expected
// display is derived from the number of clock edges since reset release.
module tb_pc_wb_display_scanner;

  localparam int REFRESH_DIV = 4;
  localparam int CNT_W       = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] wd_in = '0;
  logic        freeze = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  always #5 clk = ~clk;

  pc_wb_display_scanner #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk            (clk),
    .Rst            (rst),
    .PC_pin_out     (pc_in),
    .write_data_pin (wd_in),
    .Freeze         (freeze),
    .An             (an),
    .Seg            (seg),
    .Frame_start    (frame_start)
  );

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         edges   = 0;
  logic [15:0] m_pc   = '0;
  logic [15:0] m_wd   = '0;
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %h, expected %h (edges=%0d)", tag, $time, got, want, edges);
    end
  endtask

  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int d);
    int          k;
    int          grp;
    logic [7:0]  s;
    grp = (d < 4) ? int'(m_wd) : int'(m_pc);
    k   = d % 4;
    s   = hex_seg(4'((grp >> (4 * k)) & 15));
    if (d == 4) s = s & 8'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && (grp >> (4 * k)) == 0) s = (d == 4) ? 8'h7F : 8'hFF;
`endif
    return s;
  endfunction

  task automatic check_outputs();
    logic [7:0] e_an;
    logic [7:0] e_seg;
    int         d;
    if (edges < REFRESH_DIV) begin
      e_an  = 8'hFF;
      e_seg = 8'hFF;
    end else begin
      d     = (edges / REFRESH_DIV - 1) % 8;
      e_an  = ~(8'h01 << d);
      e_seg = exp_seg(d);
    end
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("frame_start", frame_start, (edges % 32) == 4);
    if (edges >= 4 && edges % 4 == 0 && exp_q.size() > 0)
      check("frame_seg", seg, exp_q.pop_front());
  endtask

  // One clock: model update at the edge, check 1 ns later, return at negedge
  task automatic step();
    @(posedge clk);
    if (rst) begin
      edges = 0;
      m_pc  = '0;
      m_wd  = '0;
    end else begin
      edges++;
      if (edges % 32 == 4 && !freeze) begin
        m_pc = pc_in[15:0];
        m_wd = wd_in[15:0];
      end
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Digits 0..7 packed most-significant first
  task automatic push_frame(input logic [63:0] v);
    for (int i = 0; i < 8; i++) exp_q.push_back(v[63 - 8 * i -: 8]);
  endtask

  initial begin
    // Reset hold for 200 ns
    run(20);

    pc_in = 32'h0040_0010;
    wd_in = 32'h0000_ABCD;
    rst   = 1'b0;
    run(3);
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(64'hA1C6_8388_40F9_FFFF);
`else
    push_frame(64'hA1C6_8388_40F9_C0C0);
`endif
    run(32);

    // Frozen frame keeps ABCD despite new write data
    freeze = 1'b1;
    wd_in  = 32'h0000_1234;
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(64'hA1C6_8388_40F9_FFFF);
`else
    push_frame(64'hA1C6_8388_40F9_C0C0);
`endif
    run(32);

    freeze = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(64'h99B0_A4F9_40F9_FFFF);
`else
    push_frame(64'h99B0_A4F9_40F9_C0C0);
`endif
    run(32);

    pc_in = 32'h0000_0010;
    wd_in = 32'h0000_0005;
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(64'h92FF_FFFF_40F9_FFFF);
`else
    push_frame(64'h92C0_C0C0_40F9_C0C0);
`endif
    run(32);
    check("queue_drained", exp_q.size(), 0);

    // Advance into digit 5 of the next frame, then reset between clock edges
    run(21);
    check("pre_reset_digit5", an, 8'hDF);
    #2;
    rst   = 1'b1;
    edges = 0;
    m_pc  = '0;
    m_wd  = '0;
    #1;
    check("async_an", an, 8'hFF);
    check("async_seg", seg, 8'hFF);
    check("async_frame_start", frame_start, 1'b0);
    run(3);
    rst   = 1'b0;
    pc_in = 32'hFFFF_0ACE;
    wd_in = 32'h1234_00B7;
    run(40);

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pc_in = $urandom;
        if ($urandom_range(0, 1) == 0) pc_in[15:0] = 16'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) begin
        wd_in = $urandom;
        if ($urandom_range(0, 1) == 0) wd_in[15:0] = 16'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pc_wb_display_scanner.md
Name: pc_wb_display_scanner

Overview:
- Board-side consumer of the processor's two observation outputs, `PC_pin_out` and `write_data_pin`, which are otherwise only watched by the simulation bench.
- Snapshots both values once per display frame and time-multiplexes them onto an 8-digit, common-anode seven-segment display.
- Digits 7..4 show PC[15:0]; digits 3..0 show write-back data[15:0].
- Sits at the board top level beside the processor top, on the same clock.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Must be ≥ 2. The bench uses 4.
- CNT_W, 17: divider counter width. Must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- Clk  in  1  system clock
- Rst  in  1  reset, asynchronous, active-high
- PC_pin_out  in  32  current PC from the processor
- write_data_pin  in  32  write-back data from the processor
- Freeze  in  1  1 = hold the current snapshot
- An  out  8  digit anodes, active-low, one-hot-low
- Seg  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}
- Frame_start  out  1  one-cycle pulse when a new snapshot is latched

Behaviour:
- Reset (asynchronous):
  - divider count = 0, digit_idx = 7, snapshots = 0.
  - An = 8'hFF, Seg = 8'hFF, Frame_start = 0.
- Divider:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (count == REFRESH_DIV-1).
- On each tick edge:
  - digit_idx advances by 1, wrapping 7 -> 0.
  - An and Seg are registered for the new digit_idx at that same edge.
  - An = ~(1 << new idx).
- Frame wrap (digit_idx goes 7 -> 0):
  - If Freeze = 0: pc_snap <= PC_pin_out[15:0] and wd_snap <= write_data_pin[15:0].
  - Seg for digit 0 is decoded from the values being latched, not from the stale snapshot.
  - If Freeze = 1: snapshots hold.
  - Frame_start is 1 for exactly the cycle after this edge, regardless of Freeze.
- First tick after reset selects digit 0 and latches the first snapshot.
- Nibble mapping:
  - digit d < 4 shows wd_snap[4d+3:4d].
  - digit d ≥ 4 shows pc_snap[4(d-4)+3:4(d-4)].
- Hex decode, active-low gfedcba:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Decimal point: lit (dp = 0) only on digit 4, as the PC/data separator. On all other digits dp = 1.
- Between ticks, An and Seg are stable; no glitches.
- Freeze changes take effect only at the next frame wrap.
- Rst asserted mid-frame returns immediately to the reset state. The scan restarts at digit 0 on the first tick after release.
- PC_pin_out[31:16] and write_data_pin[31:16] are ignored.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: within each 4-digit group, zero nibbles above the most-significant nonzero nibble are blanked.
  - Blanked digit: Seg = 8'hFF, except digit 4's dp stays lit (Seg = 8'h7F).
  - Digits 0 and 4 are never blanked.
  - Blanking is computed from the snapshot.
- Undefined: all digits always display their hex value.

Decomposition:
- Shared package `display_pkg` holds:
  - the 16-entry active-low segment table,
  - SEG_BLANK = 8'hFF,
  - DP_DIGIT = 4,
  - NUM_DIGITS = 8.
- One sub-module: `hex_to_7seg`. It is purely combinational (4-bit nibble in, 7-bit active-low segments out) and is instantiated once on the muxed nibble.

Test Plan (REFRESH_DIV = 4):
- Reset hold: Rst = 1 for 200 ns -> An = FF, Seg = FF. First tick after release gives An = FE and Frame_start pulses once.
- PC = 0x00400010, write data = 0x0000ABCD, feature off -> one frame, digits 0..7 give Seg = A1, C6, 83, 88, 40, F9, C0, C0. An walks FE, FD, …, 7F with 4 cycles per digit.
- Freeze = 1 after the first frame, then change write data to 0x1234 -> next frame still shows ABCD. Release Freeze -> the frame after that shows digits 0..3 = 99, B0, A4, F9.
- Rst asserted at digit 5 -> An and Seg go to FF within the same cycle, without a clock edge. After release the scan restarts at digit 0 and the snapshot is re-latched.
- Divider wrap: count never exceeds 3. Exactly 32 cycles per frame; Frame_start period = 32 cycles.
- LEADING_ZERO_BLANK_EN, PC = 0x0010, write data = 0x0005 -> digits 0..7 = 92, FF, FF, FF, 40, F9, FF, FF.
